// File: rtl/fifo_flops_sync.sv
// rtl/fifo_flops_sync.sv - single-clock flip-flop FIFO with arbitrary depth, level flags and sticky errors
//
// Purpose:
//   Synchronous single-clock queue for buffering between producer and consumer
//   stages. DEPTH need not be a power of two; pointers wrap explicitly at
//   DEPTH-1. Provides occupancy count, programmable almost-full/almost-empty,
//   sticky overflow/underflow and a synchronous flush.
//
// Configuration macro:
//   FIFO_FWFT_EN  defined   -> first-word-fall-through: Dout shows the head word
//                              combinationally whenever data is pending.
//                 undefined -> registered read: Dout loads the head word on an
//                              accepted pop and holds it otherwise.
//
// Ports:
//   clk           clock, all state on posedge
//   rst           asynchronous active-low reset
//   clr           synchronous flush (pointers/count/flags/Dout), wins over push/pop
//   Din           write data, sampled on an accepted push
//   push, pop     write / read requests
//   Dout          read data
//   full          count == DEPTH
//   pndng         count != 0
//   almost_full   count >= AF_LVL
//   almost_empty  count <= AE_LVL
//   count         occupancy 0..DEPTH
//   overflow      sticky, set by a refused push
//   underflow     sticky, set by a refused pop

module fifo_flops_sync #(
  parameter int DEPTH  = 16,
  parameter int BITS   = 8,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic [BITS-1:0]            Din,
  input  logic                       push,
  input  logic                       pop,
  output logic [BITS-1:0]            Dout,
  output logic                       full,
  output logic                       pndng,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_LVL);
  localparam logic [CW-1:0] AE_C     = CW'(AE_LVL);

  logic [BITS-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            push_acc;
  logic            pop_acc;

  // Explicit wrap so non power-of-2 depths never address past the last entry.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Flags are pure decodes of the registered count.
  assign full         = (count == DEPTH_C);
  assign pndng        = (count != '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // A pop on a full FIFO frees a slot in the same cycle, so the push may use it.
  assign pop_acc  = pop & pndng;
  assign push_acc = push & (~full | pop_acc);

  // Storage: cleared only by reset; flush leaves contents in place.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (!clr && push_acc) begin
      mem[wr_ptr] <= Din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop_acc) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push_acc && !pop_acc) begin
        count <= count + CW'(1);
      end else if (pop_acc && !push_acc) begin
        count <= count - CW'(1);
      end
      if (push && !push_acc) begin
        overflow <= 1'b1;
      end
      if (pop && !pop_acc) begin
        underflow <= 1'b1;
      end
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is visible as soon as it is stored; zero when empty.
  assign Dout = pndng ? mem[rd_ptr] : '0;
`else
  logic [BITS-1:0] dout_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q <= '0;
    end else if (clr) begin
      dout_q <= '0;
    end else if (pop_acc) begin
      dout_q <= mem[rd_ptr];
    end
  end

  assign Dout = dout_q;
`endif

endmodule

// File: tb/tb_fifo_flops_sync.sv
// tb/tb_fifo_flops_sync.sv - self-checking bench for fifo_flops_sync against a queue reference model

module tb_fifo_flops_sync;

  localparam int DEPTH = 5;
  localparam int BITS  = 8;
  localparam int AFL   = DEPTH - 2;
  localparam int AEL   = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            clr = 1'b0;
  logic [BITS-1:0] Din = '0;
  logic            push = 1'b0;
  logic            pop = 1'b0;
  logic [BITS-1:0] Dout;
  logic            full, pndng, almost_full, almost_empty, overflow, underflow;
  logic [2:0]      count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [BITS-1:0] q[$];
  logic            m_ovf = 1'b0;
  logic            m_udf = 1'b0;
  logic [BITS-1:0] m_dout = '0;

  fifo_flops_sync #(.DEPTH(DEPTH), .BITS(BITS)) dut (
    .clk(clk), .rst(rst), .clr(clr), .Din(Din), .push(push), .pop(pop),
    .Dout(Dout), .full(full), .pndng(pndng), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BITS-1:0] exp_dout();
`ifdef FIFO_FWFT_EN
    return (q.size() != 0) ? q[0] : '0;
`else
    return m_dout;
`endif
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".count"},  32'(count),        32'(q.size()));
    chk({tag, ".full"},   32'(full),         32'(q.size() == DEPTH));
    chk({tag, ".pndng"},  32'(pndng),        32'(q.size() != 0));
    chk({tag, ".afull"},  32'(almost_full),  32'(q.size() >= AFL));
    chk({tag, ".aempty"}, 32'(almost_empty), 32'(q.size() <= AEL));
    chk({tag, ".ovf"},    32'(overflow),     32'(m_ovf));
    chk({tag, ".udf"},    32'(underflow),    32'(m_udf));
    chk({tag, ".dout"},   32'(Dout),         32'(exp_dout()));
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_dout = '0;
  endtask

  // Applies one cycle of inputs, advances the model at the edge, then checks.
  task automatic step(input string tag, input logic c, input logic pu, input logic po,
                      input logic [BITS-1:0] d);
    bit pa, wa;
    @(negedge clk);
    clr = c; push = pu; pop = po; Din = d;
    @(posedge clk);
    if (c) begin
      q.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_dout = '0;
    end else begin
      pa = po && (q.size() != 0);
      wa = pu && ((q.size() < DEPTH) || pa);
      if (pa) m_dout = q.pop_front();
      if (wa) q.push_back(d);
      if (pu && !wa) m_ovf = 1'b1;
      if (po && !pa) m_udf = 1'b1;
    end
    #1;
    check_all(tag);
    clr = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    model_reset();
    check_all("reset");
    chk("reset.aempty_const", 32'(almost_empty), 32'd1);
    rst = 1'b1;

    // 1: fill, overflow, drain in order
    for (int i = 0; i < DEPTH; i++) step("t1_fill", 0, 1, 0, 8'h11 + 8'(i));
    chk("t1.full_const", 32'(full), 32'd1);
    step("t1_ovf", 0, 1, 0, 8'h99);
    chk("t1.ovf_const", 32'(overflow), 32'd1);
    for (int i = 0; i < DEPTH; i++) step("t1_drain", 0, 0, 1, 8'h00);
    step("t1_idle", 0, 0, 0, 8'h00);
`ifndef FIFO_FWFT_EN
    chk("t1.last_word", 32'(Dout), 32'h15);
`endif
    step("t1_clr", 1, 0, 0, 8'h00);

    // 2: interleaved push/pop at count 3 wraps pointers
    for (int i = 0; i < 3; i++) step("t2_pre", 0, 1, 0, 8'h20 + 8'(i));
    for (int i = 0; i < 12; i++) step("t2_mix", 0, 1, 1, 8'h30 + 8'(i));
    chk("t2.count_const", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) step("t2_drain", 0, 0, 1, 8'h00);

    // 3: full + push + pop
    for (int i = 0; i < DEPTH; i++) step("t3_fill", 0, 1, 0, 8'h50 + 8'(i));
    step("t3_both", 0, 1, 1, 8'hAA);
    chk("t3.ovf_const", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) step("t3_drain", 0, 0, 1, 8'h00);
`ifndef FIFO_FWFT_EN
    chk("t3.aa_last", 32'(Dout), 32'hAA);
`endif

    // 4: empty + push + pop
    step("t4_both", 0, 1, 1, 8'h42);
    chk("t4.udf_const", 32'(underflow), 32'd1);
`ifdef FIFO_FWFT_EN
    chk("t4.fwft_head", 32'(Dout), 32'h42);
`endif
    step("t4_pop", 0, 0, 1, 8'h00);
`ifndef FIFO_FWFT_EN
    chk("t4.read", 32'(Dout), 32'h42);
`endif

    // 5: clr with push at count 3 and overflow set
    for (int i = 0; i < DEPTH + 1; i++) step("t5_fill", 0, 1, 0, 8'h60 + 8'(i));
    step("t5_pop", 0, 0, 1, 8'h00);
    step("t5_pop", 0, 0, 1, 8'h00);
    step("t5_clr", 1, 1, 0, 8'h77);
    chk("t5.count_const", 32'(count), 32'd0);

    // 6: asynchronous reset between edges mid-burst
    for (int i = 0; i < 3; i++) step("t6_burst", 0, 1, 0, 8'h80 + 8'(i));
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("t6_async_rst");
    @(negedge clk);
    rst = 1'b1;
    step("t6_resume", 0, 1, 0, 8'h91);
    step("t6_resume", 0, 1, 0, 8'h92);
    step("t6_resume", 0, 0, 1, 8'h00);
    step("t6_resume", 0, 0, 1, 8'h00);

    // Randomized traffic with phases biased toward filling or draining
    for (int i = 0; i < 400; i++) begin
      int bias;
      bias = ((i / 40) % 2 == 0) ? 3 : 1;
      step("rand", ($urandom % 25) == 0, ($urandom % 4) < bias,
           ($urandom % 4) >= bias, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
